// File: rtl/spi_frame_master.sv
// rtl/spi_frame_master.sv - SPI frame master: 8-bit header {r_w, adr} plus NBIT data bits, MSB first
//
// Purpose: turns one start request into one framed SPI transfer on a shared
// sclk/mosi/cs bus. mosi is updated together with the sclk fall and held for a
// full CLK_DIV low phase before every rise. A CLK_DIV hold follows the last
// rise, then a CS_GAP window with cs high. Every output is registered.
//
// Ports:
//   i_clk      system clock (also the slaves' oversampling clock)
//   i_rst_n    asynchronous reset, active low
//   i_start    one-cycle request, honoured only while o_busy is low
//   i_wr       header bit 7 (1 = write, 0 = read/no-op)
//   i_adr      7-bit slave address
//   i_data     NBIT payload
//   i_miso     serial read data           (SPI_MISO_RD_EN only)
//   o_rd_data  word captured from i_miso  (SPI_MISO_RD_EN only)
//   o_sclk     SPI clock, idles low
//   o_mosi     serial data, idles high
//   o_cs       chip select, active low
//   o_busy     high from the cycle after an accepted start until done
//   o_done     one-cycle pulse when the cs gap completes
//
// Optional feature: define SPI_MISO_RD_EN to add the miso read-back path.

module spi_frame_master #(
    parameter int NBIT    = 8,
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic            i_wr,
    input  logic [6:0]      i_adr,
    input  logic [NBIT-1:0] i_data,
`ifdef SPI_MISO_RD_EN
    input  logic            i_miso,
    output logic [NBIT-1:0] o_rd_data,
`endif
    output logic            o_sclk,
    output logic            o_mosi,
    output logic            o_cs,
    output logic            o_busy,
    output logic            o_done
);

    localparam int FL   = 8 + NBIT;
    localparam int PMAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int PW   = $clog2(PMAX);
    localparam int CW   = $clog2(FL + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_HOLD,
        S_GAP
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_phase, w_phase_nxt;
    logic [CW-1:0]   r_bits,  w_bits_nxt;
    logic [FL-1:0]   r_shreg, w_shreg_nxt;
    logic            w_last;
    logic            w_done_nxt;
    logic            w_cs_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase + 1'b1;
        w_bits_nxt  = r_bits;
        w_shreg_nxt = r_shreg;
        w_done_nxt  = 1'b0;
        w_last      = (r_state == S_GAP) ? (r_phase == PW'(CS_GAP - 1))
                                         : (r_phase == PW'(CLK_DIV - 1));
        case (r_state)
            S_IDLE: begin
                w_phase_nxt = '0;
                if (i_start) begin
                    w_state_nxt = S_SETUP;
                    w_shreg_nxt = {i_wr, i_adr, i_data};
                    w_bits_nxt  = CW'(FL);
                end
            end
            S_SETUP: begin
                if (w_last) begin
                    w_state_nxt = S_HIGH;
                    w_phase_nxt = '0;
                end
            end
            S_HIGH: begin
                if (w_last) begin
                    w_phase_nxt = '0;
                    w_bits_nxt  = r_bits - 1'b1;
                    if (r_bits == CW'(1)) begin
                        w_state_nxt = S_HOLD;
                    end else begin
                        // Shifting on entry to LOW puts the next bit on mosi
                        // in the same cycle that sclk falls.
                        w_state_nxt = S_LOW;
                        w_shreg_nxt = {r_shreg[FL-2:0], 1'b0};
                    end
                end
            end
            S_LOW: begin
                if (w_last) begin
                    w_state_nxt = S_HIGH;
                    w_phase_nxt = '0;
                end
            end
            S_HOLD: begin
                if (w_last) begin
                    w_state_nxt = S_GAP;
                    w_phase_nxt = '0;
                end
            end
            S_GAP: begin
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                    w_phase_nxt = '0;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_phase_nxt = '0;
            end
        endcase
        w_cs_nxt = !(w_state_nxt inside {S_SETUP, S_HIGH, S_LOW, S_HOLD});
    end

    // Outputs are registered from the next-state decode so they line up with
    // r_state without any input-to-output combinational path.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_phase <= '0;
            r_bits  <= '0;
            r_shreg <= '0;
            o_sclk  <= 1'b0;
            o_mosi  <= 1'b1;
            o_cs    <= 1'b1;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_bits  <= w_bits_nxt;
            r_shreg <= w_shreg_nxt;
            o_sclk  <= (w_state_nxt == S_HIGH);
            o_mosi  <= w_cs_nxt ? 1'b1 : w_shreg_nxt[FL-1];
            o_cs    <= w_cs_nxt;
            o_busy  <= (w_state_nxt != S_IDLE);
            o_done  <= w_done_nxt;
        end
    end

`ifdef SPI_MISO_RD_EN
    logic [NBIT-1:0] r_rx;
    logic            w_rise;

    // Sample on the edge that raises sclk; r_bits still holds the count of
    // bits left including the current one, so <= NBIT marks the data bits.
    assign w_rise = (w_state_nxt == S_HIGH) && (r_state != S_HIGH);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx      <= '0;
            o_rd_data <= '0;
        end else begin
            if (w_rise && (r_bits <= CW'(NBIT))) begin
                r_rx <= {r_rx[NBIT-2:0], i_miso};
            end
            if (w_done_nxt) begin
                o_rd_data <= r_rx;
            end
        end
    end
`endif

endmodule
